sram16_ctrl: RTL
================

// Module: sram16_ctrl
// PURPOSE
//  Bus slave that maps the 32-bit word bus produced by the CPU bus interface onto a
//  16-bit asynchronous external SRAM. Each bus word access becomes two halfword accesses:
//  low half at the even SRAM address, high half at the odd one (little-endian).
//  Byte writes never reach this block; they arrive as word read + word write.
//  The block sits directly downstream of the CPU bus interface, behind the address decoder.
// PARAMETERS
//  WAIT    2   cycles each halfword read or write strobe is held; legal range >=1
//  ADDR_W  20  SRAM halfword address width; bus bits addr[ADDR_W:2] are used
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset: synchronous, active-high
//  stb         in   1       bus strobe; held high by master until ack
//  we          in   1       1=write word, 0=read word; valid with stb
//  addr        in   22      word address [23:2]
//  data_in     in   32      write data; valid with stb & we
//  data_out    out  32      read data; registered
//  ack         out  1       one-cycle completion pulse; registered
//  sram_addr   out  ADDR_W  halfword address {addr[ADDR_W:2], hsel}
//  sram_d_in   in   16      data from SRAM pads
//  sram_d_out  out  16      data to SRAM pads
//  sram_d_oe   out  1       pad output enable: 1=drive sram_d_out
//  sram_ce_n   out  1       chip enable, active low
//  sram_oe_n   out  1       output enable, active low
//  sram_we_n   out  1       write enable, active low
//  sram_ub_n   out  1       upper byte enable, active low
//  sram_lb_n   out  1       lower byte enable, active low
// BEHAVIOUR
//  Reset values:
//   - ack=0, data_out=0, sram_addr=0, sram_d_out=0, sram_d_oe=0
//   - sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n all 1; state IDLE
//  Signal registration:
//   - All SRAM controls are registered outputs; they must not glitch.
//   - addr, we and data_in are latched at the start of an access and ignored afterwards.
//  States and transitions:
//   - IDLE: stb=1 latches the request -> RD_LO if we=0, WR_LO_S if we=1.
//   - RD_LO: ce_n=0, oe_n=0, ub/lb_n=0, hsel=0, held WAIT cycles;
//     sram_d_in is captured into data_out[15:0] on the last cycle -> RD_HI.
//   - RD_HI: same with hsel=1; captures data_out[31:16] -> DONE.
//   - WR_LO_S: 1 setup cycle; ce_n=0, we_n=1, d_oe=1, d_out=data[15:0], hsel=0.
//   - WR_LO_P: we_n=0 for WAIT cycles -> WR_HI_S.
//   - WR_HI_S / WR_HI_P: same for data[31:16] with hsel=1; end -> DONE.
//     we_n rises at least 1 cycle before sram_addr changes.
//   - DONE: ack=1 for exactly 1 cycle; all SRAM controls inactive, d_oe=0 -> IDLE.
//  Latency (cycle 0 = IDLE edge that samples stb=1):
//   - read: ack high in cycle 2*WAIT+1
//   - write: ack high in cycle 2*WAIT+3
//  Back-to-back accesses:
//   - stb still high in the IDLE cycle after DONE starts a new access.
//   - A read acked and immediately followed by a write (byte-write pattern) needs no idle gap.
//  Read data: data_out is updated only by reads and holds its value between reads.
//  Wait counter: width clog2(WAIT)+1, reloaded at every phase entry.
//  Boundary conditions:
//   - stb dropped mid-access (protocol violation): the access still completes and ack
//     is still pulsed.
//   - Rst mid-access: next edge forces all controls inactive and d_oe=0, without
//     completing the access; no ack is issued.
//   - Address bits above ADDR_W are ignored (aliasing); addr wraps modulo 2^(ADDR_W-1) words.
// TESTING  (WAIT=2, ADDR_W=20, SRAM behavioural model)
//  1. Write 0x12345678 to addr 0x000004 -> SRAM[8]=0x5678, SRAM[9]=0x1234;
//     ack in cycle 7 only; we_n low 2 cycles per half.
//  2. Read addr 0x000004 after test 1 -> data_out=0x12345678, ack in cycle 5,
//     oe_n low 4 cycles, d_oe=0 throughout.
//  3. Byte-write pattern: read 0xCAFEBABE at addr 0x10, stb held, then write 0xCAFEBA55
//     -> write starts in the cycle after ack; SRAM[0x20]=0xBA55.
//  4. Assert rst during WR_HI_P -> next edge: we_n=1, ce_n=1, d_oe=0, ack=0;
//     SRAM[odd] unchanged or fully written, never torn by a late we_n.
//  5. Write 0xAAAA5555 to addr 0x080001 -> lands at SRAM[2] and SRAM[3] (alias of
//     word 1); readback at word 1 = 0xAAAA5555.
//  6. Drop stb at cycle 2 of a read -> ack still pulses at cycle 5; block returns to
//     IDLE and stays idle.

Source files
------------

// File: rtl/sram16_ctrl.sv
// 32-bit bus slave onto a 16-bit asynchronous SRAM: every word access is split into
// two halfword accesses, low half at the even halfword address, high half at the odd one.
module sram16_ctrl #(
   parameter int WAIT   = 2,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stb,
   input  logic              we,
   input  logic [21:0]       addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              ack,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [15:0]       sram_d_in,
   output logic [15:0]       sram_d_out,
   output logic              sram_d_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   localparam int CW = $clog2(WAIT) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_LO   = 3'd1,
      RD_HI   = 3'd2,
      WR_LO_S = 3'd3,
      WR_LO_P = 3'd4,
      WR_HI_S = 3'd5,
      WR_HI_P = 3'd6,
      DONE    = 3'd7
   } state_t;

   state_t            state_r;
   logic [CW-1:0]     cnt_r;
   logic [ADDR_W-2:0] addr_r;
   logic [15:0]       data_hi_r;

   // Word-address bits above the SRAM range alias onto the same locations.
   logic unused_s;
   assign unused_s = ^addr[21:ADDR_W-1];

   // Access sequencer; every SRAM control and bus response is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= CNT_ZERO;
         addr_r     <= {(ADDR_W-1){1'b0}};
         data_hi_r  <= 16'h0000;
         data_out   <= 32'h0000_0000;
         ack        <= 1'b0;
         sram_addr  <= {ADDR_W{1'b0}};
         sram_d_out <= 16'h0000;
         sram_d_oe  <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_ub_n  <= 1'b1;
         sram_lb_n  <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               ack <= 1'b0;
               if (stb) begin
                  addr_r    <= addr[ADDR_W-2:0];
                  data_hi_r <= data_in[31:16];
                  cnt_r     <= CNT_LOAD;
                  sram_addr <= {addr[ADDR_W-2:0], 1'b0};
                  sram_ce_n <= 1'b0;
                  sram_ub_n <= 1'b0;
                  sram_lb_n <= 1'b0;
                  if (we) begin
                     sram_d_out <= data_in[15:0];
                     sram_d_oe  <= 1'b1;
                     state_r    <= WR_LO_S;
                  end else begin
                     sram_oe_n <= 1'b0;
                     state_r   <= RD_LO;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_LO: begin
               if (cnt_r == CNT_ZERO) begin
                  data_out[15:0] <= sram_d_in;
                  sram_addr      <= {addr_r, 1'b1};
                  cnt_r          <= CNT_LOAD;
                  state_r        <= RD_HI;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            RD_HI: begin
               if (cnt_r == CNT_ZERO) begin
                  data_out[31:16] <= sram_d_in;
                  sram_ce_n       <= 1'b1;
                  sram_oe_n       <= 1'b1;
                  sram_ub_n       <= 1'b1;
                  sram_lb_n       <= 1'b1;
                  ack             <= 1'b1;
                  state_r         <= DONE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            WR_LO_S: begin
               sram_we_n <= 1'b0;
               cnt_r     <= CNT_LOAD;
               state_r   <= WR_LO_P;
            end
            WR_LO_P: begin
               if (cnt_r == CNT_ZERO) begin
                  sram_we_n  <= 1'b1;
                  sram_d_out <= data_hi_r;
                  cnt_r      <= CNT_LOAD;
                  state_r    <= WR_HI_S;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            // Address moves only once we_n has been high for a full cycle.
            WR_HI_S: begin
               sram_addr <= {addr_r, 1'b1};
               sram_we_n <= 1'b0;
               cnt_r     <= CNT_LOAD;
               state_r   <= WR_HI_P;
            end
            WR_HI_P: begin
               if (cnt_r == CNT_ZERO) begin
                  sram_we_n <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_ub_n <= 1'b1;
                  sram_lb_n <= 1'b1;
                  sram_d_oe <= 1'b0;
                  ack       <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            DONE: begin
               ack     <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               ack       <= 1'b0;
               sram_d_oe <= 1'b0;
               sram_ce_n <= 1'b1;
               sram_oe_n <= 1'b1;
               sram_we_n <= 1'b1;
               sram_ub_n <= 1'b1;
               sram_lb_n <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
